w_update_sub: RTL

Kurtosis fixed-point update stage for the 4x4 weight block, directly downstream of the 3w multiplier stage. It computes w+ = E{x(w^T x)^3} - 3w elementwise and registers the result. It then accumulates the squared norm of each row of w+ over four column cycles, which the following normalisation stage consumes. A start/busy/valid handshake sequences it within the one-unit FastICA iteration.

---
 rtl/fastica_pkg.sv | 38 +++
 rtl/w_update_sub_sq_acc_row.sv | 36 +++
 rtl/w_update_sub.sv | 120 ++++++++++++
 3 files changed

// File: rtl/fastica_pkg.sv
// Shared types and constants for the FastICA weight-update datapath.
// Build option: define SUB_SAT_EN to clamp the w+ difference to the element range;
// leave it undefined to wrap the difference to the low DW bits instead.
package fastica_pkg;

  localparam int DW = 26;
  localparam int N  = 4;
  localparam int NW = 2*DW + 2;

  typedef logic signed [DW-1:0] elem_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SQ   = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam elem_t SAT_MAX = {1'b0, {(DW-1){1'b1}}};
  localparam elem_t SAT_MIN = {1'b1, {(DW-1){1'b0}}};

  // w+ element: ie - iw3, formed one bit wider than an element.
  function automatic elem_t sub_elem(input elem_t a, input elem_t b);
`ifdef SUB_SAT_EN
    logic signed [DW:0] d;
    d = {a[DW-1], a} - {b[DW-1], b};
    // The two top bits disagree only when the result left the element range.
    if (d[DW] != d[DW-1]) begin
      sub_elem = d[DW] ? SAT_MIN : SAT_MAX;
    end else begin
      sub_elem = d[DW-1:0];
    end
`else
    // Wrapping keeps the low DW bits, which is plain DW-bit subtraction.
    sub_elem = a - b;
`endif
  endfunction

endpackage

// File: rtl/w_update_sub_sq_acc_row.sv
// sq_acc_row: squares one w+ element per cycle and accumulates it into the
// row's squared norm. Clear has priority over enable.
module sq_acc_row
  import fastica_pkg::*;
(
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_clr,
  input  logic          i_en,
  input  elem_t         i_elem,
  output logic [NW-1:0] o_norm
);

  logic [2*DW-1:0]        w_ext;
  logic signed [2*DW-1:0] w_sq;
  logic [NW-1:0]          r_norm;

  // A signed square is never negative, so it zero-extends into the accumulator.
  assign w_ext  = {{DW{i_elem[DW-1]}}, i_elem};
  assign w_sq   = $signed(w_ext) * $signed(w_ext);
  assign o_norm = r_norm;

  // Row accumulator: cleared on acceptance, summed during the column sweep.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_norm <= '0;
    end else if (i_clr) begin
      r_norm <= '0;
    end else if (i_en) begin
      r_norm <= r_norm + {{(NW-2*DW){1'b0}}, w_sq};
    end else begin
      r_norm <= r_norm;
    end
  end

endmodule

// File: rtl/w_update_sub.sv
// w_update_sub: kurtosis update w+ = E{x(w^T x)^3} - 3w for the 4x4 weight
// block, then the per-row squared norms of w+ over four column cycles.
// Build option: SUB_SAT_EN selects saturating (defined) or wrapping (undefined)
// subtraction; squares and accumulation are the same in both builds.
module w_update_sub
  import fastica_pkg::*;
(
  input  logic                 clk_sub,
  input  logic                 rst_sub,
  input  logic                 en_sub,
  input  logic signed [DW-1:0] ie11, ie12, ie13, ie14, ie21, ie22, ie23, ie24,
  input  logic signed [DW-1:0] ie31, ie32, ie33, ie34, ie41, ie42, ie43, ie44,
  input  logic signed [DW-1:0] iw3_11, iw3_12, iw3_13, iw3_14, iw3_21, iw3_22, iw3_23, iw3_24,
  input  logic signed [DW-1:0] iw3_31, iw3_32, iw3_33, iw3_34, iw3_41, iw3_42, iw3_43, iw3_44,
  output logic signed [DW-1:0] ow11, ow12, ow13, ow14, ow21, ow22, ow23, ow24,
  output logic signed [DW-1:0] ow31, ow32, ow33, ow34, ow41, ow42, ow43, ow44,
  output logic [NW-1:0]        onorm1, onorm2, onorm3, onorm4,
  output logic                 busy,
  output logic                 o_valid
);

  elem_t         w_ie  [N*N];
  elem_t         w_iw3 [N*N];
  elem_t         r_ow  [N*N];
  elem_t         w_col_elem [N];
  logic [NW-1:0] w_norm [N];
  state_t        r_state, w_next;
  logic [1:0]    r_col;
  logic          r_busy, r_valid;
  logic          w_accept, w_sq_en;

  // Flatten the element ports row-major: index = 4*(row-1) + (col-1).
  assign w_ie[0]  = ie11; assign w_ie[1]  = ie12; assign w_ie[2]  = ie13; assign w_ie[3]  = ie14;
  assign w_ie[4]  = ie21; assign w_ie[5]  = ie22; assign w_ie[6]  = ie23; assign w_ie[7]  = ie24;
  assign w_ie[8]  = ie31; assign w_ie[9]  = ie32; assign w_ie[10] = ie33; assign w_ie[11] = ie34;
  assign w_ie[12] = ie41; assign w_ie[13] = ie42; assign w_ie[14] = ie43; assign w_ie[15] = ie44;

  assign w_iw3[0]  = iw3_11; assign w_iw3[1]  = iw3_12; assign w_iw3[2]  = iw3_13; assign w_iw3[3]  = iw3_14;
  assign w_iw3[4]  = iw3_21; assign w_iw3[5]  = iw3_22; assign w_iw3[6]  = iw3_23; assign w_iw3[7]  = iw3_24;
  assign w_iw3[8]  = iw3_31; assign w_iw3[9]  = iw3_32; assign w_iw3[10] = iw3_33; assign w_iw3[11] = iw3_34;
  assign w_iw3[12] = iw3_41; assign w_iw3[13] = iw3_42; assign w_iw3[14] = iw3_43; assign w_iw3[15] = iw3_44;

  assign ow11 = r_ow[0];  assign ow12 = r_ow[1];  assign ow13 = r_ow[2];  assign ow14 = r_ow[3];
  assign ow21 = r_ow[4];  assign ow22 = r_ow[5];  assign ow23 = r_ow[6];  assign ow24 = r_ow[7];
  assign ow31 = r_ow[8];  assign ow32 = r_ow[9];  assign ow33 = r_ow[10]; assign ow34 = r_ow[11];
  assign ow41 = r_ow[12]; assign ow42 = r_ow[13]; assign ow43 = r_ow[14]; assign ow44 = r_ow[15];

  assign onorm1  = w_norm[0];
  assign onorm2  = w_norm[1];
  assign onorm3  = w_norm[2];
  assign onorm4  = w_norm[3];
  assign busy    = r_busy;
  assign o_valid = r_valid;

  // Inputs are sampled only on an accepting edge; en_sub is ignored elsewhere.
  assign w_accept = (r_state == IDLE) && en_sub;
  assign w_sq_en  = (r_state == SQ);

  // Next-state decode: one pass through SQ per column, then a single DONE cycle.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (en_sub) w_next = SQ;
        else        w_next = IDLE;
      end
      SQ: begin
        if (r_col == 2'd3) w_next = DONE;
        else               w_next = SQ;
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_sub or posedge rst_sub) begin
    if (rst_sub) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Datapath: capture w+ on acceptance, step the column during SQ, register flags.
  always_ff @(posedge clk_sub or posedge rst_sub) begin
    if (rst_sub) begin
      r_col   <= 2'd0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      for (int i = 0; i < N*N; i++) r_ow[i] <= '0;
    end else begin
      r_busy  <= (w_next != IDLE);
      r_valid <= (r_state == SQ) && (r_col == 2'd3);
      if (w_accept) begin
        r_col <= 2'd0;
        for (int i = 0; i < N*N; i++) r_ow[i] <= sub_elem(w_ie[i], w_iw3[i]);
      end else if (w_sq_en) begin
        r_col <= r_col + 2'd1;
      end else begin
        r_col <= r_col;
      end
    end
  end

  // One accumulator per row, fed with that row's element at the current column.
  for (genvar r = 0; r < N; r++) begin : g_row
    assign w_col_elem[r] = r_ow[{2'(r), r_col}];

    sq_acc_row u_row (
      .i_clk  (clk_sub),
      .i_rst  (rst_sub),
      .i_clr  (w_accept),
      .i_en   (w_sq_en),
      .i_elem (w_col_elem[r]),
      .o_norm (w_norm[r])
    );
  end

endmodule
